// File: rtl/pwr_guard_pkg.sv
// Shared state and LED-mode definitions for the N-channel power-relay guard.
package pwr_guard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_COUNT = 3'd2,
    ST_TRIP  = 3'd3,
    ST_HOLD  = 3'd4
  } chan_state_e;

  typedef enum logic [1:0] {
    LED_OFF  = 2'd0,
    LED_ON   = 2'd1,
    LED_FAST = 2'd2,
    LED_SLOW = 2'd3
  } led_mode_e;

  // LED pattern selected by a channel's state
  function automatic led_mode_e led_mode(input chan_state_e st);
    case (st)
      ST_IDLE:  return LED_OFF;
      ST_ARMED: return LED_ON;
      ST_COUNT: return LED_FAST;
      default:  return LED_SLOW;
    endcase
  endfunction

endpackage

// File: rtl/pwr_guard_chan.sv
// One guarded channel: request/overload FSM, overload timer and LED pattern.
module pwr_guard_chan
  import pwr_guard_pkg::*;
#(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_i,
  input  logic          blink_fast_i,
  input  logic          blink_slow_i,
  input  logic          req_i,
  input  logic          ovl_s_i,
  input  logic          fault_clr_i,
  input  logic [TW-1:0] preload_i,
  output logic          closed_o,
  output logic          trip_o,
  output logic          fault_o,
  output logic          led_o
);

  chan_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          expire;

  // State and timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and timer update; a fault clear also cancels an expiry on the same clock
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    expire  = (state_q == ST_COUNT) && req_i && !ovl_s_i && tick_i && (timer_q == '0);
    if (fault_clr_i && ((state_q == ST_TRIP) || (state_q == ST_HOLD) || expire)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timer_d = preload_i;
          if (req_i) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          timer_d = preload_i;
          if (!req_i)        state_d = ST_IDLE;
          else if (!ovl_s_i) state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (!req_i) begin
            state_d = ST_IDLE;
          end else if (ovl_s_i) begin
            state_d = ST_ARMED;
            timer_d = preload_i;
          end else if (tick_i) begin
            if (timer_q == '0) state_d = ST_TRIP;
            else               timer_d = timer_q - TW'(1);
          end
        end
        ST_TRIP: begin
          if (!req_i) state_d = ST_HOLD;
        end
        ST_HOLD: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // LED pattern mux
  always_comb begin
    led_o = 1'b0;
    case (led_mode(state_q))
      LED_OFF:  led_o = 1'b0;
      LED_ON:   led_o = 1'b1;
      LED_FAST: led_o = blink_fast_i;
      LED_SLOW: led_o = blink_slow_i;
      default:  led_o = 1'b0;
    endcase
  end

  assign closed_o = (state_q == ST_ARMED) || (state_q == ST_COUNT);
  assign trip_o   = (state_q == ST_TRIP);
  assign fault_o  = (state_q == ST_TRIP) || (state_q == ST_HOLD);

endmodule

// File: rtl/pwr_guard_nch.sv
// N-channel UUT power-relay guard: input synchronisers, per-channel guards,
// trip gating of the relays and registered outputs.
module pwr_guard_nch
  import pwr_guard_pkg::*;
#(
  parameter int unsigned CH          = 3,
  parameter int unsigned TW          = 8,
  parameter int unsigned GLOBAL_TRIP = 1,
  parameter int unsigned SYNC        = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             blink_fast,
  input  logic             blink_slow,
  input  logic [CH-1:0]    relay_req,
  input  logic             gnd_req,
  input  logic [CH-1:0]    ovl_ok,
  input  logic [CH*TW-1:0] preload,
  input  logic [CH-1:0]    fault_clr,
  input  logic             emrgcy_off,
  output logic [CH-1:0]    pwr,
  output logic             pwr_gnd,
  output logic [CH-1:0]    led,
  output logic             led_gnd,
  output logic [CH-1:0]    fault,
  output logic             alert,
  output logic             uut_pwr_fail
);

  logic [SYNC-1:0][CH-1:0] ovl_sync_q;
  logic [SYNC-1:0]         emrg_sync_q;
  logic [CH-1:0]           ovl_s;
  logic                    emrg_s;
  logic [CH-1:0]           closed, trip, flt, led_c;
  logic                    any_trip, gate;
  logic [CH-1:0]           pwr_q, led_q, fault_q;
  logic                    pwr_gnd_q, alert_q;

  // Synchronisers; they reset to "no overload" and "emergency off" so the
  // relays stay open until real input values have filled the chain
  always_ff @(posedge clk) begin
    if (reset) begin
      ovl_sync_q  <= '1;
      emrg_sync_q <= '1;
    end else begin
      ovl_sync_q  <= {ovl_sync_q[SYNC-2:0], ovl_ok};
      emrg_sync_q <= {emrg_sync_q[SYNC-2:0], emrgcy_off};
    end
  end

  assign ovl_s  = ovl_sync_q[SYNC-1];
  assign emrg_s = emrg_sync_q[SYNC-1];

  for (genvar i = 0; i < CH; i++) begin : g_chan
    pwr_guard_chan #(.TW(TW)) u_chan (
      .clk          (clk),
      .reset        (reset),
      .tick_i       (tick),
      .blink_fast_i (blink_fast),
      .blink_slow_i (blink_slow),
      .req_i        (relay_req[i]),
      .ovl_s_i      (ovl_s[i]),
      .fault_clr_i  (fault_clr[i]),
      .preload_i    (preload[i*TW +: TW]),
      .closed_o     (closed[i]),
      .trip_o       (trip[i]),
      .fault_o      (flt[i]),
      .led_o        (led_c[i])
    );
  end

  assign any_trip = |trip;
  assign gate     = emrg_s || ((GLOBAL_TRIP != 0) && any_trip);

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pwr_q     <= '0;
      pwr_gnd_q <= 1'b0;
      led_q     <= '0;
      fault_q   <= '0;
      alert_q   <= 1'b0;
    end else begin
      pwr_q     <= closed & {CH{~gate}};
      pwr_gnd_q <= gnd_req & ~gate;
      led_q     <= led_c;
      fault_q   <= flt;
      alert_q   <= any_trip;
    end
  end

  assign pwr          = pwr_q;
  assign pwr_gnd      = pwr_gnd_q;
  assign led          = led_q;
  assign led_gnd      = pwr_gnd_q;
  assign fault        = fault_q;
  assign alert        = alert_q;
  assign uut_pwr_fail = alert_q;

endmodule
